uart_fifo_ctrl: RTL and testbench



---
 rtl/uart_fifo_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - buffered CPU front end for the UART register interface
//
// Purpose: owns all traffic to the UART registers. A six-state sequencer polls
// the UART, moves received bytes into an RX FIFO and feeds bytes from a TX FIFO
// into the transmitter only when the UART reports idle.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   a, d, we        CPU word address, write data (byte in d[31:24]), write strobe
//   spo             CPU read data, combinational from a
//   irq             registered, high while the RX FIFO holds data
//   u_a, u_d, u_we  UART address, write data, write strobe
//   u_spo           UART read data (combinational in the UART)

module uart_fifo_ctrl #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic [2:0]  u_a,
  output logic [31:0] u_d,
  output logic        u_we,
  input  logic [31:0] u_spo
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [2:0] {
    S_POLL_RX,
    S_READ_RX,
    S_CLR_RX,
    S_POLL_TX,
    S_SEND,
    S_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;

  logic tx_ovf_q, tx_ovf_d;
  logic rx_ovf_q, rx_ovf_d;
  logic uart_idle_q, uart_idle_d;
  logic irq_q, irq_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic cpu_tx_push, cpu_rx_pop, cpu_clr;
  logic tx_pop, rx_push;
  logic tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
  logic [7:0] tx_head, rx_head;

  // Low CPU data bits and low UART read bits carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{d[23:0], u_spo[23:0]};

  // Full/empty come from registered counts only.
  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem[tx_rd_q];
  assign rx_head  = rx_mem[rx_rd_q];

  assign cpu_tx_push = we && (a == 3'd0);
  assign cpu_rx_pop  = we && (a == 3'd1);
  assign cpu_clr     = we && (a == 3'd2);

  // Sequencer: one state per cycle, outputs are Moore outputs of state_q.
  always_comb begin
    state_d     = state_q;
    uart_idle_d = uart_idle_q;
    u_a         = 3'd0;
    u_we        = 1'b0;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    case (state_q)
      S_POLL_RX: begin
        u_a     = 3'd1;
        state_d = u_spo[24] ? S_READ_RX : S_POLL_TX;
      end
      S_READ_RX: begin
        u_a     = 3'd0;
        rx_push = 1'b1;
        state_d = S_CLR_RX;
      end
      S_CLR_RX: begin
        u_a     = 3'd1;
        u_we    = 1'b1;
        state_d = S_POLL_TX;
      end
      S_POLL_TX: begin
        u_a         = 3'd2;
        uart_idle_d = u_spo[24];
        state_d     = (u_spo[24] && !tx_empty) ? S_SEND : S_POLL_RX;
      end
      S_SEND: begin
        u_a     = 3'd0;
        u_we    = 1'b1;
        tx_pop  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // UART still reports idle for one cycle after the write.
        u_a     = 3'd2;
        state_d = S_POLL_RX;
      end
      default: state_d = S_POLL_RX;
    endcase
  end

  // Gate the head byte so the UART data bus reads zero while nothing is queued.
  assign u_d = tx_empty ? 32'h0 : {tx_head, 24'h0};

  // FIFO bookkeeping. A push into a full FIFO is dropped even if a pop happens
  // in the same cycle, since fullness is judged on the registered count.
  always_comb begin
    tx_push_ok = cpu_tx_push && !tx_full;
    tx_pop_ok  = tx_pop && !tx_empty;
    rx_push_ok = rx_push && !rx_full;
    rx_pop_ok  = cpu_rx_pop && !rx_empty;

    tx_wr_d = tx_push_ok ? tx_wr_q + TX_AW'(1) : tx_wr_q;
    tx_rd_d = tx_pop_ok  ? tx_rd_q + TX_AW'(1) : tx_rd_q;
    rx_wr_d = rx_push_ok ? rx_wr_q + RX_AW'(1) : rx_wr_q;
    rx_rd_d = rx_pop_ok  ? rx_rd_q + RX_AW'(1) : rx_rd_q;

    tx_cnt_d = tx_cnt_q;
    if (tx_push_ok && !tx_pop_ok) begin
      tx_cnt_d = tx_cnt_q + (TX_AW+1)'(1);
    end else if (!tx_push_ok && tx_pop_ok) begin
      tx_cnt_d = tx_cnt_q - (TX_AW+1)'(1);
    end

    rx_cnt_d = rx_cnt_q;
    if (rx_push_ok && !rx_pop_ok) begin
      rx_cnt_d = rx_cnt_q + (RX_AW+1)'(1);
    end else if (!rx_push_ok && rx_pop_ok) begin
      rx_cnt_d = rx_cnt_q - (RX_AW+1)'(1);
    end

    // Overflow flags are sticky; a new overflow beats a same-cycle clear.
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (cpu_clr) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
    if (cpu_tx_push && tx_full) begin
      tx_ovf_d = 1'b1;
    end
    if (rx_push && rx_full) begin
      rx_ovf_d = 1'b1;
    end

    // irq tracks the next count so it moves one cycle after the push or pop.
    irq_d = (rx_cnt_d != '0);
  end

  always_comb begin
    spo = 32'h0;
    case (a)
      3'd0: spo = rx_empty ? 32'h0 : {rx_head, 24'h0};
      3'd1: spo = {4'b0, tx_ovf_q, rx_ovf_q, ~tx_full, ~rx_empty, 24'h0};
      3'd2: spo = {7'b0, tx_empty & uart_idle_q, 24'h0};
      default: spo = 32'h0;
    endcase
  end

  assign irq = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_POLL_RX;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      uart_idle_q <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      uart_idle_q <= uart_idle_d;
      irq_q       <= irq_d;
    end
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (!rst && tx_push_ok) begin
      tx_mem[tx_wr_q] <= d[31:24];
    end
    if (!rst && rx_push_ok) begin
      rx_mem[rx_wr_q] <= u_spo[31:24];
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - scoreboard bench for uart_fifo_ctrl with a behavioural UART

module tb_uart_fifo_ctrl;

  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        irq;
  logic [2:0]  u_a;
  logic [31:0] u_d;
  logic        u_we;
  logic [31:0] u_spo;

  uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .d     (d),
    .we    (we),
    .spo   (spo),
    .irq   (irq),
    .u_a   (u_a),
    .u_d   (u_d),
    .u_we  (u_we),
    .u_spo (u_spo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART: rx_new/rx_data set by injection (set beats clear),
  // transmitter goes busy one cycle after the data write.
  logic [7:0] m_rx_data;
  logic       m_rx_new;
  logic       m_pend;
  int         m_cnt;
  logic       inj;
  logic [7:0] inj_byte;

  always @(posedge clk) begin
    if (rst) begin
      m_rx_data <= 8'h0;
      m_rx_new  <= 1'b0;
      m_pend    <= 1'b0;
      m_cnt     <= 0;
    end else begin
      if (inj) begin
        m_rx_data <= inj_byte;
        m_rx_new  <= 1'b1;
      end else if (u_we && u_a == 3'd1) begin
        m_rx_new <= 1'b0;
      end
      if (u_we && u_a == 3'd0) begin
        m_pend <= 1'b1;
      end else if (m_pend) begin
        m_pend <= 1'b0;
        m_cnt  <= FRAME;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always_comb begin
    u_spo = 32'h0;
    case (u_a)
      3'd0: u_spo = {m_rx_data, 24'h0};
      3'd1: u_spo = {7'b0, m_rx_new, 24'h0};
      3'd2: u_spo = {7'b0, (m_cnt == 0), 24'h0};
      default: u_spo = 32'h0;
    endcase
  end

  // Scoreboard queues
  typedef struct {
    int          sel;   // 0 spo, 1 irq, 2 u_a, 3 u_we, 4 u_d
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [7:0] b;
    int         stamp;
    bit         lat;
  } tx_t;

  chk_t chk_q[$];
  tx_t  exp_tx[$];
  logic chk_strobe;
  int   n_vec = 0;
  int   n_bad = 0;

  chk_t        mc;
  tx_t         mt;
  logic [31:0] mact;

  always @(negedge clk) begin
    if (chk_strobe) begin
      n_vec++;
      if (chk_q.size() == 0) begin
        n_bad++;
        $display("FAIL chk_queue: strobe with no expectation queued");
      end else begin
        mc = chk_q.pop_front();
        case (mc.sel)
          0: mact = spo;
          1: mact = {31'h0, irq};
          2: mact = {29'h0, u_a};
          3: mact = {31'h0, u_we};
          default: mact = u_d;
        endcase
        if (mact !== mc.exp) begin
          n_bad++;
          $display("FAIL %s: got %08h expected %08h", mc.name, mact, mc.exp);
        end
      end
    end
    if (u_we && u_a == 3'd0) begin
      n_vec++;
      if (exp_tx.size() == 0) begin
        n_bad++;
        $display("FAIL tx_send: unexpected byte %02h sent, none queued", u_d[31:24]);
      end else begin
        mt = exp_tx.pop_front();
        if (u_d[31:24] !== mt.b) begin
          n_bad++;
          $display("FAIL tx_send: got %02h expected %02h", u_d[31:24], mt.b);
        end
        n_vec++;
        if (!(m_cnt == 0 && !m_pend)) begin
          n_bad++;
          $display("FAIL tx_idle: send while uart busy, cnt %0d expected 0", m_cnt);
        end
        if (mt.lat) begin
          n_vec++;
          if ((cyc - mt.stamp) < 2 || (cyc - mt.stamp) > 6) begin
            n_bad++;
            $display("FAIL tx_latency: got %0d cycles expected 2..6", cyc - mt.stamp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
    chk_strobe = 1'b1;
    tick();
    chk_strobe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
    a = addr;
    chk(0, exp, name);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] b);
    a  = addr;
    d  = {b, 24'h0};
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic tx(input logic [7:0] b, input bit sent, input bit lat);
    tx_t t;
    t.b     = b;
    t.stamp = cyc;
    t.lat   = lat;
    if (sent) exp_tx.push_back(t);
    wr(3'd0, b);
  endtask

  task automatic uart_rx(input logic [7:0] b);
    inj_byte = b;
    inj      = 1'b1;
    tick();
    inj      = 1'b0;
  endtask

  task automatic timeout(input string name);
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    a = 3'd0; d = 32'h0; we = 1'b0; inj = 1'b0; inj_byte = 8'h0;
    chk_strobe = 1'b0;
    rst = 1'b1;

    // Reset state
    tick();
    tick();
    chk(2, 32'd1, "reset_u_a");
    chk(3, 32'd0, "reset_u_we");
    chk(4, 32'h0, "reset_u_d");
    chk(1, 32'd0, "reset_irq");
    rst = 1'b0;
    rd(3'd1, 32'h0200_0000, "reset_status");
    rd(3'd2, 32'h0100_0000, "reset_tx_idle");
    rd(3'd0, 32'h0, "reset_rx_read");
    rd(3'd5, 32'h0, "unmapped_read");

    // Back-to-back TX burst
    tx(8'h41, 1'b1, 1'b1);
    tx(8'h42, 1'b1, 1'b0);
    tx(8'h43, 1'b1, 1'b0);
    rd(3'd2, 32'h0, "tx_busy_read2");
    k = 0;
    while (!(exp_tx.size() == 0 && m_cnt == 0 && !m_pend) && k < 1000) begin tick(); k++; end
    if (!(exp_tx.size() == 0 && m_cnt == 0 && !m_pend)) timeout("tx_burst_drain");
    repeat (10) tick();
    rd(3'd2, 32'h0100_0000, "tx_idle_after_drain");

    // TX overflow while the UART is busy
    tx(8'h00, 1'b1, 1'b0);
    k = 0;
    while (exp_tx.size() != 0 && k < 20) begin tick(); k++; end
    if (exp_tx.size() != 0) timeout("tx_prime_send");
    for (int i = 0; i < 17; i++) tx(8'(8'h10 + i), (i < 16), 1'b0);
    rd(3'd1, 32'h0800_0000, "stat_tx_full_ovf");
    wr(3'd2, 8'h0);
    rd(3'd1, 32'h0000_0000, "stat_ovf_cleared_full");
    k = 0;
    while (!(exp_tx.size() == 0 && m_cnt == 0 && !m_pend) && k < 3000) begin tick(); k++; end
    if (!(exp_tx.size() == 0 && m_cnt == 0 && !m_pend)) timeout("tx_ovf_drain");
    repeat (10) tick();
    rd(3'd1, 32'h0200_0000, "stat_after_tx_drain");
    rd(3'd2, 32'h0100_0000, "idle_after_tx_drain");

    // Single RX byte and irq
    uart_rx(8'h5A);
    k = 0;
    while (!irq && k < 8) begin tick(); k++; end
    chk(1, 32'd1, "irq_after_rx");
    rd(3'd0, 32'h5A00_0000, "rx_read0");
    rd(3'd1, 32'h0300_0000, "stat_rx_pending");
    wr(3'd1, 8'h0);
    chk(1, 32'd0, "irq_after_pop");
    rd(3'd0, 32'h0, "rx_read0_empty");
    wr(3'd1, 8'h0);
    rd(3'd1, 32'h0200_0000, "pop_empty_noop");

    // RX overflow: 17 bytes, first 16 kept in order
    for (int i = 0; i < 17; i++) begin
      uart_rx(8'(8'h80 + i));
      k = 0;
      while (m_rx_new && k < 20) begin tick(); k++; end
      if (m_rx_new) timeout("rx_collect");
      tick();
    end
    rd(3'd1, 32'h0700_0000, "stat_rx_ovf");
    for (int i = 0; i < 16; i++) begin
      rd(3'd0, {8'(8'h80 + i), 24'h0}, "rx_fifo_order");
      wr(3'd1, 8'h0);
    end
    chk(1, 32'd0, "irq_after_drain");
    wr(3'd2, 8'h0);
    rd(3'd1, 32'h0200_0000, "stat_rx_ovf_cleared");

    // rx_new set in the same cycle as CLR_RX: second byte still collected
    uart_rx(8'hA1);
    k = 0;
    while (!(u_we && u_a == 3'd1) && k < 20) begin tick(); k++; end
    if (!(u_we && u_a == 3'd1)) timeout("clr_rx_wait");
    uart_rx(8'hB2);
    k = 0;
    while (m_rx_new && k < 20) begin tick(); k++; end
    if (m_rx_new) timeout("rx_collision_collect");
    tick();
    tick();
    rd(3'd0, 32'hA100_0000, "collision_first");
    wr(3'd1, 8'h0);
    rd(3'd0, 32'hB200_0000, "collision_second");
    wr(3'd1, 8'h0);
    chk(1, 32'd0, "irq_after_collision");

    // Reset during SEND
    tx(8'h61, 1'b1, 1'b0);
    tx(8'h62, 1'b1, 1'b0);
    k = 0;
    while (!(u_we && u_a == 3'd0) && k < 20) begin tick(); k++; end
    if (!(u_we && u_a == 3'd0)) timeout("send_wait");
    rst = 1'b1;
    tick();
    exp_tx.delete();
    chk(3, 32'd0, "u_we_in_reset");
    chk(2, 32'd1, "u_a_in_reset");
    rst = 1'b0;
    chk(3, 32'd0, "u_we_after_reset");
    repeat (20) tick();
    rd(3'd1, 32'h0200_0000, "stat_after_send_reset");
    rd(3'd2, 32'h0100_0000, "idle_after_send_reset");

    // Reset during READ_RX
    uart_rx(8'h77);
    k = 0;
    while (!(u_a == 3'd0 && !u_we) && k < 20) begin tick(); k++; end
    if (!(u_a == 3'd0 && !u_we)) timeout("read_rx_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(3, 32'd0, "u_we_after_rx_reset");
    repeat (5) tick();
    chk(1, 32'd0, "irq_after_rx_reset");
    rd(3'd0, 32'h0, "rx_empty_after_reset");
    rd(3'd1, 32'h0200_0000, "stat_after_rx_reset");

    repeat (5) tick();
    if (chk_q.size() != 0 || exp_tx.size() != 0) begin
      n_bad++;
      $display("FAIL leftovers: %0d checks and %0d tx bytes pending, expected 0",
               chk_q.size(), exp_tx.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
